// File: rtl/bus_drive_pkg.sv
// Shared types and default timing constants for the bus drive sequencer.
package bus_drive_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_SETUP_CYCLES = 1;
    localparam int unsigned DEF_DRIVE_CYCLES = 2;
    localparam int unsigned DEF_TURN_CYCLES  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_e;

    // Word as presented to the two buffer groups: hi -> a2, lo -> a1
    typedef struct packed {
        logic [NIB_W-1:0] hi;
        logic [NIB_W-1:0] lo;
    } word_t;

    // Stage counter load value for a phase lasting 'cycles' cycles
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

    // Odd parity bit: total number of ones including this bit is odd
    function automatic logic odd_parity(input word_t w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/bus_drive_seq_if.sv
// Producer and bus-side signals of the bus drive sequencer.
// Optional par signal present only with BUS_DRIVE_PARITY_EN.
interface bus_drive_seq_if;
    import bus_drive_pkg::*;

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              bus_grant;
    logic [NIB_W-1:0]  a1;
    logic [NIB_W-1:0]  a2;
    logic              g1_n;
    logic              g2_n;
    logic              busy;
    logic              abort;
`ifdef BUS_DRIVE_PARITY_EN
    logic              par;

    modport slave  (input  wr_data, wr_valid, bus_grant,
                    output wr_ready, a1, a2, g1_n, g2_n, busy, abort, par);
    modport master (output wr_data, wr_valid, bus_grant,
                    input  wr_ready, a1, a2, g1_n, g2_n, busy, abort, par);
`else
    modport slave  (input  wr_data, wr_valid, bus_grant,
                    output wr_ready, a1, a2, g1_n, g2_n, busy, abort);
    modport master (output wr_data, wr_valid, bus_grant,
                    input  wr_ready, a1, a2, g1_n, g2_n, busy, abort);
`endif

endinterface

// File: rtl/bus_drive_fifo.sv
// Staging FIFO: power-of-two depth, registered ready, head word visible combinationally.
module bus_drive_fifo
    import bus_drive_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              ready_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign ready   = ready_q;

    // Occupancy update; simultaneous push and pop cancel
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally at power-of-two depth; ready tracks next-cycle not-full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/bus_drive_seq.sv
// Bus drive sequencer: stages words in a FIFO and drives each onto two
// buffer groups with setup / drive / turnaround timing.
// Optional macro BUS_DRIVE_PARITY_EN adds the registered odd-parity output par.
module bus_drive_seq
    import bus_drive_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int unsigned DRIVE_CYCLES = DEF_DRIVE_CYCLES,
    parameter int unsigned TURN_CYCLES  = DEF_TURN_CYCLES
) (
    input logic           clk,
    input logic           rst_n,
    bus_drive_seq_if.slave bus
);

    logic              rst_sync_n;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ready;
    logic              fifo_push;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              pop_c;
    logic              abort_c;

    word_t             drv_q;
    logic              g_n_q;
    logic              busy_q;
    logic              abort_q;

    // Reset asserts asynchronously, releases on the first edge so the second edge can push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_n <= 1'b0;
        else        rst_sync_n <= 1'b1;
    end

    assign fifo_push = bus.wr_valid && fifo_ready;

    bus_drive_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_sync_n),
        .push    (fifo_push),
        .pop     (pop_c),
        .wr_data (bus.wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ready   (fifo_ready)
    );

    // FSM state and stage counter register
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter reload on every entry, pop and abort decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop_c   = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.bus_grant) begin
                    pop_c   = 1'b1;
                    state_d = ST_SETUP;
                    cnt_d   = cnt_load(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (!bus.bus_grant) begin
                    abort_c = 1'b1;
                    state_d = ST_TURN;
                    cnt_d   = cnt_load(TURN_CYCLES);
                end else if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                    cnt_d   = cnt_load(DRIVE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (!bus.bus_grant) begin
                    abort_c = 1'b1;
                    state_d = ST_TURN;
                    cnt_d   = cnt_load(TURN_CYCLES);
                end else if (cnt_q == '0) begin
                    state_d = ST_TURN;
                    cnt_d   = cnt_load(TURN_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            drv_q   <= '0;
            g_n_q   <= 1'b1;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (pop_c) drv_q <= word_t'(fifo_rd_data);
            g_n_q   <= (state_d != ST_DRIVE);
            busy_q  <= (state_d != ST_IDLE);
            abort_q <= abort_c;
        end
    end

`ifdef BUS_DRIVE_PARITY_EN
    logic par_q;

    // Parity captured alongside the driven word
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n)  par_q <= 1'b1;
        else if (pop_c)   par_q <= odd_parity(word_t'(fifo_rd_data));
    end

    assign bus.par = par_q;
`endif

    assign bus.wr_ready = fifo_ready;
    assign bus.a1       = drv_q.lo;
    assign bus.a2       = drv_q.hi;
    assign bus.g1_n     = g_n_q;
    assign bus.g2_n     = g_n_q;
    assign bus.busy     = busy_q;
    assign bus.abort    = abort_q;

endmodule

// File: tb/tb_bus_drive_seq.sv
// Directed bench for bus_drive_seq with default parameters.
module tb_bus_drive_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_drive_seq_if bif();

    bus_drive_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect a word to enter SETUP at the next negedge, then skip its remaining four cycles
    task automatic expect_word(input string tag, input logic [7:0] w);
        @(negedge clk);
        chk(tag, {bif.a2, bif.a1}, w);
        chk({tag, "_busy"}, 8'(bif.busy), 8'd1);
        chk({tag, "_g1n"}, 8'(bif.g1_n), 8'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] w);
        bif.wr_data  = w;
        bif.wr_valid = 1'b1;
        @(negedge clk);
        bif.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bif.wr_valid  = 1'b0;
        bif.wr_data   = 8'h00;
        bif.bus_grant = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_wr_ready", 8'(bif.wr_ready), 8'd1);
        chk("rst_a", {bif.a2, bif.a1}, 8'h00);
        chk("rst_g1n", 8'(bif.g1_n), 8'd1);
        chk("rst_g2n", 8'(bif.g2_n), 8'd1);
        chk("rst_busy", 8'(bif.busy), 8'd0);
        chk("rst_abort", 8'(bif.abort), 8'd0);
`ifdef BUS_DRIVE_PARITY_EN
        chk("rst_par", 8'(bif.par), 8'd1);
`endif

        // Release with a word offered: first edge ignored, second edge pushes
        rst_n         = 1'b1;
        bif.wr_data   = 8'hA5;
        bif.wr_valid  = 1'b1;
        bif.bus_grant = 1'b1;
        @(negedge clk);
        chk("sync_busy_e1", 8'(bif.busy), 8'd0);
        @(negedge clk);
        bif.wr_valid = 1'b0;
        chk("sync_busy_e2", 8'(bif.busy), 8'd0);
        @(negedge clk);
        chk("a5_setup_a1", 8'(bif.a1), 8'h05);
        chk("a5_setup_a2", 8'(bif.a2), 8'h0A);
        chk("a5_setup_g1n", 8'(bif.g1_n), 8'd1);
        chk("a5_setup_g2n", 8'(bif.g2_n), 8'd1);
        chk("a5_setup_busy", 8'(bif.busy), 8'd1);
        @(negedge clk);
        chk("a5_drive1_g1n", 8'(bif.g1_n), 8'd0);
        chk("a5_drive1_g2n", 8'(bif.g2_n), 8'd0);
        @(negedge clk);
        chk("a5_drive2_g1n", 8'(bif.g1_n), 8'd0);
        chk("a5_drive2_a", {bif.a2, bif.a1}, 8'hA5);
        @(negedge clk);
        chk("a5_turn_g1n", 8'(bif.g1_n), 8'd1);
        chk("a5_turn_busy", 8'(bif.busy), 8'd1);
        chk("a5_turn_abort", 8'(bif.abort), 8'd0);
        @(negedge clk);
        chk("a5_idle_busy", 8'(bif.busy), 8'd0);
        chk("a5_idle_a", {bif.a2, bif.a1}, 8'hA5);

        // Fill with grant low: four accepted, fifth refused, then drained in order
        bif.bus_grant = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bif.wr_data  = 8'(k);
            bif.wr_valid = 1'b1;
            @(negedge clk);
            chk("fill_ready", 8'(bif.wr_ready), 8'(k < 4));
            chk("fill_busy", 8'(bif.busy), 8'd0);
        end
        bif.wr_valid  = 1'b0;
        bif.bus_grant = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            expect_word("drain_word", 8'(w));
        end
        @(negedge clk);
        chk("fifth_refused_busy", 8'(bif.busy), 8'd0);
        chk("fifth_refused_a", {bif.a2, bif.a1}, 8'h04);

        // Grant dropped during the second DRIVE cycle of 0x3C
        push_word(8'h3C);
        @(negedge clk);
        chk("3c_setup_a", {bif.a2, bif.a1}, 8'h3C);
        @(negedge clk);
        chk("3c_drive1_g1n", 8'(bif.g1_n), 8'd0);
        @(negedge clk);
        chk("3c_drive2_g1n", 8'(bif.g1_n), 8'd0);
        bif.bus_grant = 1'b0;
        @(negedge clk);
        chk("3c_abort_g1n", 8'(bif.g1_n), 8'd1);
        chk("3c_abort_g2n", 8'(bif.g2_n), 8'd1);
        chk("3c_abort_pulse", 8'(bif.abort), 8'd1);
        @(negedge clk);
        chk("3c_abort_end", 8'(bif.abort), 8'd0);
        chk("3c_idle_busy", 8'(bif.busy), 8'd0);
        bif.bus_grant = 1'b1;
        repeat (3) @(negedge clk);
        chk("3c_no_redrive", 8'(bif.busy), 8'd0);

        // Grant dropped in SETUP: enables never assert
        push_word(8'h77);
        @(negedge clk);
        chk("77_setup_a", {bif.a2, bif.a1}, 8'h77);
        bif.bus_grant = 1'b0;
        @(negedge clk);
        chk("77_abort_g1n", 8'(bif.g1_n), 8'd1);
        chk("77_abort_pulse", 8'(bif.abort), 8'd1);
        chk("77_turn_busy", 8'(bif.busy), 8'd1);
        @(negedge clk);
        chk("77_idle_busy", 8'(bif.busy), 8'd0);
        bif.bus_grant = 1'b1;
        repeat (2) @(negedge clk);
        chk("77_no_redrive", 8'(bif.busy), 8'd0);

        // Full FIFO with pop and wr_valid in the same cycle
        bif.bus_grant = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        chk("full_ready", 8'(bif.wr_ready), 8'd0);
        bif.wr_data   = 8'h55;
        bif.wr_valid  = 1'b1;
        bif.bus_grant = 1'b1;
        @(negedge clk);
        bif.wr_valid = 1'b0;
        chk("full_pop_ready", 8'(bif.wr_ready), 8'd1);
        chk("full_pop_a", {bif.a2, bif.a1}, 8'h11);
        repeat (4) @(negedge clk);
        expect_word("occ_word", 8'h22);
        expect_word("occ_word", 8'h33);
        expect_word("occ_word", 8'h44);
        @(negedge clk);
        chk("occ_55_refused", 8'(bif.busy), 8'd0);

        // Reset asserted mid-drive with a word still queued
        bif.bus_grant = 1'b0;
        push_word(8'h99);
        push_word(8'h66);
        bif.bus_grant = 1'b1;
        @(negedge clk);
        chk("99_setup_a", {bif.a2, bif.a1}, 8'h99);
        @(negedge clk);
        chk("99_drive_g1n", 8'(bif.g1_n), 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_g1n", 8'(bif.g1_n), 8'd1);
        chk("mid_rst_g2n", 8'(bif.g2_n), 8'd1);
        chk("mid_rst_ready", 8'(bif.wr_ready), 8'd1);
        chk("mid_rst_busy", 8'(bif.busy), 8'd0);
        chk("mid_rst_a", {bif.a2, bif.a1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_empty", 8'(bif.busy), 8'd0);
        chk("post_rst_ready", 8'(bif.wr_ready), 8'd1);

`ifdef BUS_DRIVE_PARITY_EN
        push_word(8'h00);
        @(negedge clk);
        chk("par_00", 8'(bif.par), 8'd1);
        repeat (4) @(negedge clk);
        push_word(8'h01);
        @(negedge clk);
        chk("par_01", 8'(bif.par), 8'd0);
        repeat (4) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_drive_seq.md
BUS_DRIVE_SEQ -- requirements
Module: bus_drive_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: staging FIFO depth in words, power of two, 2..16.
REQ-002 Parameter SETUP_CYCLES, default 1: data-valid cycles before enables assert, 1..15.
REQ-003 Parameter DRIVE_CYCLES, default 2: cycles both enables are asserted, 1..15.
REQ-004 Parameter TURN_CYCLES, default 1: bus-release guard cycles after drive, 1..15.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_data  input  8  word to be driven.
REQ-008 wr_valid  input  1  producer offers wr_data.
REQ-009 wr_ready  output  1  FIFO can accept a word.
REQ-010 bus_grant  input  1  bus owner permits driving; level-sensitive.
REQ-011 a1  output  4  low nibble, feeds buffer group 1 data inputs.
REQ-012 a2  output  4  high nibble, feeds buffer group 2 data inputs.
REQ-013 g1_n, g2_n  output  1 each  active-low output enables for buffer groups 1 and 2.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 abort  output  1  one-cycle pulse when a drive is cut short.

Function
REQ-016 Push on the rising edge where wr_valid and wr_ready are both high; wr_ready SHALL equal NOT full, registered, with no same-cycle pass-through when full.
REQ-017 A pushed word SHALL become poppable on the following cycle; FIFO order SHALL be strict first-in first-out, with pointers wrapping modulo FIFO_DEPTH.
REQ-018 A push and a pop in the same cycle SHALL leave the occupancy count unchanged; a push while full SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, SETUP, DRIVE and TURN.
REQ-020 IDLE -> SETUP when the FIFO is not empty and bus_grant=1: pop the head word and register it into {a2,a1} at the same edge.
REQ-021 SETUP SHALL last SETUP_CYCLES cycles with g1_n=g2_n=1 and a1/a2 stable, then go to DRIVE.
REQ-022 DRIVE SHALL last DRIVE_CYCLES cycles with g1_n=g2_n=0 and a1/a2 stable, then go to TURN.
REQ-023 TURN SHALL last TURN_CYCLES cycles with g1_n=g2_n=1 and a1/a2 held, then go to IDLE; back-to-back words SHALL therefore pass through IDLE for one cycle.
REQ-024 bus_grant=0 sampled in SETUP or DRIVE SHALL move the FSM to TURN on that edge, deassert both enables and pulse abort for one cycle; the word is discarded, not re-queued.
REQ-025 g1_n and g2_n SHALL be driven from flops only, never combinationally from inputs, and SHALL always be equal.
REQ-026 The stage counter SHALL be 4 bits wide, reload at every state entry, and never wrap.

Reset
REQ-027 While rst_n=0: FSM=IDLE, FIFO empty, wr_ready=1, a1=a2=0, g1_n=g2_n=1, busy=0, abort=0.
REQ-028 Reset asserted mid-drive SHALL force g1_n=g2_n=1 immediately, without waiting for a clock edge.
REQ-029 Release of rst_n SHALL be synchronised so that the first push is possible on the second rising edge after release.

Configuration
REQ-030 Macro BUS_DRIVE_PARITY_EN, when defined, SHALL add output par (1 bit): odd parity over {a2,a1}, registered with a1/a2, reset value 1.
REQ-031 Without BUS_DRIVE_PARITY_EN the port par and all its logic SHALL be absent.

Structure
REQ-032 The FSM state enum and the default timing constants SHALL live in the shared package bus_drive_pkg.
REQ-033 The FIFO SHALL be a sub-module, bus_drive_fifo, with push/pop/full/empty/data ports, and SHALL be instantiated once.

Verification
REQ-034 Reset, then push 0xA5 with grant=1 -> SETUP 1 cycle a1=5 a2=A with enables high; DRIVE 2 cycles with g1_n=g2_n=0; TURN 1 cycle; busy for 4 cycles.
REQ-035 Push 0x01..0x05 with grant=0 -> four accepted, wr_ready=0 after the 4th; 0x05 refused; raise grant -> 0x01..0x04 driven in order.
REQ-036 Drop grant in the 2nd DRIVE cycle of 0x3C -> enables high next cycle, abort pulse of 1 cycle, 0x3C never redriven.
REQ-037 Assert rst_n=0 during DRIVE -> g1_n=g2_n=1 before the next edge; FIFO empty; wr_ready=1.
REQ-038 Full FIFO with simultaneous pop and wr_valid -> push refused that cycle; occupancy 3; wr_ready=1 on the next cycle.
REQ-039 With BUS_DRIVE_PARITY_EN defined, drive 0x00 -> par=1; drive 0x01 -> par=0.
